// File: rtl/comp2_4bit_serial.sv
// Bit-serial 4-bit two's complement negator with valid/ready handshakes.
// Operand bits are processed LSB first, one per cycle, using the copy-until-first-one rule.
//
//   state | meaning
//   IDLE  | waiting for an operand, in_ready=1
//   SHIFT | processing operand bits 0..3, one per cycle
//   DONE  | result held on out_data/out_ovf until out_ready
module comp2_4bit_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic       out_ovf,
  input  logic       out_ready
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     r_state;
  logic [3:0] r_shift;
  logic [1:0] r_cnt;
  logic       r_seen_one;

  logic       w_bit;
  logic       w_res;

  assign w_bit     = r_shift[0];
  assign w_res     = r_seen_one ? ~w_bit : w_bit;
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= 4'd0;
      r_cnt      <= 2'd0;
      r_seen_one <= 1'b0;
      out_data   <= 4'd0;
      out_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift    <= in_data;
            r_cnt      <= 2'd0;
            r_seen_one <= 1'b0;
            out_data   <= 4'd0;
            out_ovf    <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_shift         <= {1'b0, r_shift[3:1]};
          out_data[r_cnt] <= w_res;
          r_seen_one      <= r_seen_one | w_bit;
          r_cnt           <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            // Only 1000 reaches its MSB with no lower one bit seen.
            out_ovf <= w_bit & ~r_seen_one;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/comp2_4bit_serial.md
COMP2_4BIT_SERIAL -- requirements
Module: comp2_4bit_serial

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-003 rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 in_valid  input  1  in_data is valid this cycle.
REQ-005 in_data  input  4  operand I, unsigned bit pattern; bit 0 is LSB.
REQ-006 in_ready  output  1  block can accept an operand this cycle.
REQ-007 out_valid  output  1  out_data and out_ovf hold a completed result.
REQ-008 out_data  output  4  two's complement of the accepted operand: O = (~I + 1) mod 16.
REQ-009 out_ovf  output  1  accepted operand was 4'b1000, whose negation is not representable.
REQ-010 out_ready  input  1  downstream consumer takes the result this cycle.

Function
REQ-011 The block SHALL contain a 3-state FSM: IDLE, SHIFT, DONE.
REQ-012 in_ready SHALL be 1 exactly when the state is IDLE.
REQ-013 out_valid SHALL be 1 exactly when the state is DONE.
REQ-014 Accept: in IDLE with in_valid=1 -> on that edge the block SHALL load in_data into a 4-bit shift register, clear the bit counter and the seen_one flag, clear out_data, and go to SHIFT.
REQ-015 The block SHALL ignore in_valid in SHIFT and DONE, with no effect on the operand or result.
REQ-016 SHIFT processing: each cycle, one operand bit SHALL be handled, LSB first; result bit = seen_one ? ~b : b; seen_one <= seen_one | b.
REQ-017 Result bit n SHALL be written to out_data[n] on the edge that processes operand bit n.
REQ-018 The bit counter SHALL be 2 bits, 0..3; after processing bit 3 (counter==3) the FSM SHALL go to DONE.
REQ-019 Latency: the handshake edge is edge k; out_valid SHALL be 1 after edge k+4, i.e. exactly 4 SHIFT cycles.
REQ-020 out_ovf SHALL be set on entry to DONE iff the operand was 4'b1000.
REQ-021 For all other operands, out_ovf SHALL be 0; 4'b0000 SHALL give out_data=0000 and out_ovf=0.
REQ-022 DONE: out_data and out_ovf SHALL hold stable while out_ready=0, for any duration.
REQ-023 DONE with out_ready=1 -> on that edge the FSM SHALL go to IDLE; in_ready=1 the next cycle.
REQ-024 The block SHALL NOT accept a new operand in the cycle a result is consumed; throughput is 1 operand per 6 cycles minimum.
REQ-025 out_data SHALL change only on the accept edge (cleared) and during SHIFT; in DONE it SHALL remain unchanged until the next accept.

Reset
REQ-026 rst=1 on an edge SHALL force, from any state, including mid-SHIFT: state=IDLE, out_data=0000, out_ovf=0, counter=0, seen_one=0, shift register=0.
REQ-027 rst SHALL take priority over every handshake in the same cycle; an operand presented while rst=1 SHALL be discarded.
REQ-028 After reset: in_ready=1 and out_valid=0 from the first cycle after the reset edge.

Verification
REQ-029 Accept 0001, out_ready=1 -> out_valid rises 4 cycles after acceptance; out_data=1111; out_ovf=0.
REQ-030 Exhaustive sweep 0000..1111, each with out_ready=1 -> out_data == (16-I) mod 16 for every I; out_ovf=1 only for 1000 (result 1000).
REQ-031 Accept 0110, hold out_ready=0 for 10 cycles, then 1 -> out_data=1010 stable throughout; in_ready=0 until the cycle after consumption.
REQ-032 Accept 0101, toggle in_valid with in_data=1111 during SHIFT/DONE -> result is still 1011; the second operand is never accepted.
REQ-033 Accept 0011, assert rst after 2 SHIFT cycles -> next cycle IDLE, out_data=0000, out_valid=0; accept 0010 afterwards -> 1110.
REQ-034 in_valid=1 with in_data=0111 while rst=1 -> no acceptance; out_valid stays 0 for the following 6 cycles.
